// File: rtl/ram_banked.sv
// Multi-bank buffer: NUM_BANKS independent banks, each with its own registered read and write port.
// Read latency is 2 clk edges from request to s_read_valid (3 with RAM_BANKED_OUTREG_EN defined).
// No backpressure: every bank accepts a read and a write every cycle. Optional macro: RAM_BANKED_OUTREG_EN.
module ram_banked #(
    parameter int    DATA_WIDTH = 16,
    parameter int    ADDR_WIDTH = 10,
    parameter int    NUM_BANKS  = 4,
    parameter string RAM_TYPE   = "block",
    parameter string RDW_MODE   = "WRITE_FIRST"
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_BANKS-1:0]             s_read_req,
    input  logic [NUM_BANKS*ADDR_WIDTH-1:0]  s_read_addr,
    output logic [NUM_BANKS*DATA_WIDTH-1:0]  s_read_data,
    output logic [NUM_BANKS-1:0]             s_read_valid,
    input  logic [NUM_BANKS-1:0]             s_write_req,
    input  logic [NUM_BANKS*ADDR_WIDTH-1:0]  s_write_addr,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0]  s_write_data,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0]  s_write_mask
);

    localparam int DEPTH       = 2 ** ADDR_WIDTH;
    localparam bit WRITE_FIRST = (RDW_MODE == "WRITE_FIRST");

    // Catch a mistyped collision policy or an empty RAM style at elaboration time.
    if (!(RDW_MODE == "WRITE_FIRST" || RDW_MODE == "READ_FIRST")) begin : g_bad_rdw_mode
        $error("ram_banked: RDW_MODE must be WRITE_FIRST or READ_FIRST, got %s", RDW_MODE);
    end
    if (RAM_TYPE == "") begin : g_bad_ram_type
        $error("ram_banked: RAM_TYPE must not be empty");
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        // Stage-1 request registers.
        logic                  rd_req_q;
        logic [ADDR_WIDTH-1:0] rd_addr_q;
        logic                  wr_req_q;
        logic [ADDR_WIDTH-1:0] wr_addr_q;
        logic [DATA_WIDTH-1:0] wr_data_q;
        logic [DATA_WIDTH-1:0] wr_mask_q;

        // Stage-2 read result.
        logic                  rd_vld_q;
        logic [DATA_WIDTH-1:0] rd_data_q;

        // Array read word and the merged word used when a read collides with a write.
        logic [DATA_WIDTH-1:0] rd_word;
        logic [DATA_WIDTH-1:0] rd_bypass;
        logic                  collide;

        (* ram_style = RAM_TYPE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

        // Capture this bank's read and write requests; reset drops anything in flight.
        always_ff @(posedge clk) begin
            if (reset) begin
                rd_req_q  <= 1'b0;
                rd_addr_q <= '0;
                wr_req_q  <= 1'b0;
                wr_addr_q <= '0;
                wr_data_q <= '0;
                wr_mask_q <= '0;
            end else begin
                rd_req_q  <= s_read_req[b];
                rd_addr_q <= s_read_addr[b*ADDR_WIDTH +: ADDR_WIDTH];
                wr_req_q  <= s_write_req[b];
                wr_addr_q <= s_write_addr[b*ADDR_WIDTH +: ADDR_WIDTH];
                wr_data_q <= s_write_data[b*DATA_WIDTH +: DATA_WIDTH];
                wr_mask_q <= s_write_mask[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        // Detect a same-address collision and form the merged word a write-first read returns.
        always_comb begin
            rd_word   = mem[rd_addr_q];
            collide   = rd_req_q && wr_req_q && (rd_addr_q == wr_addr_q);
            rd_bypass = (rd_word & ~wr_mask_q) | (wr_data_q & wr_mask_q);
        end

        // Bit-masked array update; a write still in stage 1 when reset asserts is discarded.
        always_ff @(posedge clk) begin
            if (!reset && wr_req_q) begin
                for (int i = 0; i < DATA_WIDTH; i++) begin
                    if (wr_mask_q[i]) begin
                        mem[wr_addr_q][i] <= wr_data_q[i];
                    end
                end
            end
        end

        // Read the array; data holds its last value whenever no read completes.
        always_ff @(posedge clk) begin
            if (reset) begin
                rd_vld_q  <= 1'b0;
                rd_data_q <= '0;
            end else begin
                rd_vld_q <= rd_req_q;
                if (rd_req_q) begin
                    rd_data_q <= (WRITE_FIRST && collide) ? rd_bypass : rd_word;
                end
            end
        end

`ifdef RAM_BANKED_OUTREG_EN
        // Extra output register stage for timing closure toward the PE array.
        logic                  out_vld_q;
        logic [DATA_WIDTH-1:0] out_data_q;

        // Retime the stage-2 result by one cycle.
        always_ff @(posedge clk) begin
            if (reset) begin
                out_vld_q  <= 1'b0;
                out_data_q <= '0;
            end else begin
                out_vld_q  <= rd_vld_q;
                out_data_q <= rd_data_q;
            end
        end

        assign s_read_valid[b]                        = out_vld_q;
        assign s_read_data[b*DATA_WIDTH +: DATA_WIDTH] = out_data_q;
`else
        assign s_read_valid[b]                        = rd_vld_q;
        assign s_read_data[b*DATA_WIDTH +: DATA_WIDTH] = rd_data_q;
`endif
    end

endmodule

// File: tb/tb_ram_banked.sv
// Directed bench for ram_banked: a WRITE_FIRST and a READ_FIRST instance share all stimulus.
// Expected values are hand-computed constants; read latency follows RAM_BANKED_OUTREG_EN.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_ram_banked;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int NB = 4;
`ifdef RAM_BANKED_OUTREG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [NB-1:0]     s_read_req;
    logic [NB*AW-1:0]  s_read_addr;
    logic [NB-1:0]     s_write_req;
    logic [NB*AW-1:0]  s_write_addr;
    logic [NB*DW-1:0]  s_write_data;
    logic [NB*DW-1:0]  s_write_mask;

    logic [NB*DW-1:0]  data_wf, data_rf;
    logic [NB-1:0]     vld_wf, vld_rf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_banked #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB),
                 .RAM_TYPE("block"), .RDW_MODE("WRITE_FIRST")) dut_wf (
        .clk(clk), .reset(reset),
        .s_read_req(s_read_req), .s_read_addr(s_read_addr),
        .s_read_data(data_wf), .s_read_valid(vld_wf),
        .s_write_req(s_write_req), .s_write_addr(s_write_addr),
        .s_write_data(s_write_data), .s_write_mask(s_write_mask)
    );

    ram_banked #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB),
                 .RAM_TYPE("block"), .RDW_MODE("READ_FIRST")) dut_rf (
        .clk(clk), .reset(reset),
        .s_read_req(s_read_req), .s_read_addr(s_read_addr),
        .s_read_data(data_rf), .s_read_valid(vld_rf),
        .s_write_req(s_write_req), .s_write_addr(s_write_addr),
        .s_write_data(s_write_data), .s_write_mask(s_write_mask)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        s_read_req   = '0;
        s_read_addr  = '0;
        s_write_req  = '0;
        s_write_addr = '0;
        s_write_data = '0;
        s_write_mask = '0;
    endtask

    task automatic set_write(input int b, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [DW-1:0] m);
        s_write_req[b]            = 1'b1;
        s_write_addr[b*AW +: AW]  = a;
        s_write_data[b*DW +: DW]  = d;
        s_write_mask[b*DW +: DW]  = m;
    endtask

    task automatic set_read(input int b, input logic [AW-1:0] a);
        s_read_req[b]           = 1'b1;
        s_read_addr[b*AW +: AW] = a;
    endtask

    function automatic logic [DW-1:0] pattern(input int b, input int i);
        return 16'hC000 + 16'(b * 256) + 16'(i);
    endfunction

    task automatic test_reset;
        clear_inputs();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (vld_wf !== 4'b0000 || vld_rf !== 4'b0000) begin
                errors++;
                $display("FAIL reset_valid: got wf=%b rf=%b expected 0000", vld_wf, vld_rf);
            end
            checks++;
            if (data_wf !== 64'h0 || data_rf !== 64'h0) begin
                errors++;
                $display("FAIL reset_data: got wf=%h rf=%h expected 0", data_wf, data_rf);
            end
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write_read;
        clear_inputs();
        set_write(0, 10'h005, 16'hBEEF, 16'hFFFF);
        tick();
        clear_inputs();
        tick();
        set_read(0, 10'h005);
        tick();
        clear_inputs();
        for (int i = 1; i < LAT; i++) begin
            checks++;
            if (vld_wf !== 4'b0000) begin
                errors++;
                $display("FAIL early_valid: edge %0d got %b expected 0000", i, vld_wf);
            end
            tick();
        end
        checks++;
        if (vld_wf !== 4'b0001 || vld_rf !== 4'b0001) begin
            errors++;
            $display("FAIL basic_valid: got wf=%b rf=%b expected 0001", vld_wf, vld_rf);
        end
        checks++;
        if (data_wf[15:0] !== 16'hBEEF || data_rf[15:0] !== 16'hBEEF) begin
            errors++;
            $display("FAIL basic_data: got wf=%h rf=%h expected beef", data_wf[15:0], data_rf[15:0]);
        end
        tick();
        checks++;
        if (vld_wf !== 4'b0000) begin
            errors++;
            $display("FAIL pulse_width: got %b expected 0000", vld_wf);
        end
        checks++;
        if (data_wf[15:0] !== 16'hBEEF) begin
            errors++;
            $display("FAIL data_hold: got %h expected beef", data_wf[15:0]);
        end
    endtask

    task automatic test_masked_write;
        clear_inputs();
        set_write(1, 10'h010, 16'h1234, 16'hFFFF);
        tick();
        clear_inputs();
        set_write(1, 10'h010, 16'hABCD, 16'hFF00);
        tick();
        clear_inputs();
        tick();
        set_read(1, 10'h010);
        tick();
        clear_inputs();
        for (int i = 1; i < LAT; i++) tick();
        checks++;
        if (vld_wf !== 4'b0010) begin
            errors++;
            $display("FAIL mask_valid: got %b expected 0010", vld_wf);
        end
        checks++;
        if (data_wf[31:16] !== 16'hAB34 || data_rf[31:16] !== 16'hAB34) begin
            errors++;
            $display("FAIL mask_data: got wf=%h rf=%h expected ab34", data_wf[31:16], data_rf[31:16]);
        end
    endtask

    task automatic test_collision;
        clear_inputs();
        set_write(2, 10'h3FF, 16'h0001, 16'hFFFF);
        tick();
        clear_inputs();
        tick();
        set_write(2, 10'h3FF, 16'h00FF, 16'hFFFF);
        set_read(2, 10'h3FF);
        tick();
        clear_inputs();
        for (int i = 1; i < LAT; i++) tick();
        checks++;
        if (vld_wf[2] !== 1'b1 || vld_rf[2] !== 1'b1) begin
            errors++;
            $display("FAIL collide_valid: got wf=%b rf=%b expected bit2 set", vld_wf, vld_rf);
        end
        checks++;
        if (data_wf[47:32] !== 16'h00FF) begin
            errors++;
            $display("FAIL collide_write_first: got %h expected 00ff", data_wf[47:32]);
        end
        checks++;
        if (data_rf[47:32] !== 16'h0001) begin
            errors++;
            $display("FAIL collide_read_first: got %h expected 0001", data_rf[47:32]);
        end
        set_read(2, 10'h3FF);
        tick();
        clear_inputs();
        for (int i = 1; i < LAT; i++) tick();
        checks++;
        if (data_wf[47:32] !== 16'h00FF || data_rf[47:32] !== 16'h00FF) begin
            errors++;
            $display("FAIL collide_followup: got wf=%h rf=%h expected 00ff", data_wf[47:32], data_rf[47:32]);
        end
    endtask

    task automatic test_back_to_back;
        logic [NB*DW-1:0] exp_data;
        int k;
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            for (int b = 0; b < NB; b++) set_write(b, AW'(i), pattern(b, i), 16'hFFFF);
            tick();
        end
        clear_inputs();
        tick();
        for (int c = 0; c < 4 + LAT; c++) begin
            clear_inputs();
            if (c < 4) begin
                for (int b = 0; b < NB; b++) set_read(b, AW'(c));
            end
            tick();
            k = c - (LAT - 1);
            if (k >= 0 && k < 4) begin
                for (int b = 0; b < NB; b++) exp_data[b*DW +: DW] = pattern(b, k);
                checks++;
                if (vld_wf !== 4'b1111 || vld_rf !== 4'b1111) begin
                    errors++;
                    $display("FAIL b2b_valid[%0d]: got wf=%b rf=%b expected 1111", k, vld_wf, vld_rf);
                end
                checks++;
                if (data_wf !== exp_data || data_rf !== exp_data) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: got wf=%h rf=%h expected %h", k, data_wf, data_rf, exp_data);
                end
            end else begin
                checks++;
                if (vld_wf !== 4'b0000 || vld_rf !== 4'b0000) begin
                    errors++;
                    $display("FAIL b2b_idle[%0d]: got wf=%b rf=%b expected 0000", c, vld_wf, vld_rf);
                end
            end
        end
    endtask

    task automatic test_reset_drop;
        clear_inputs();
        set_write(3, 10'h020, 16'hAAAA, 16'hFFFF);
        tick();
        clear_inputs();
        tick();
        set_write(3, 10'h020, 16'h5555, 16'hFFFF);
        set_read(0, 10'h000);
        tick();
        clear_inputs();
        reset = 1'b1;
        set_write(3, 10'h020, 16'h7777, 16'hFFFF);
        set_read(3, 10'h020);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (vld_wf !== 4'b0000 || data_wf !== 64'h0 || vld_rf !== 4'b0000 || data_rf !== 64'h0) begin
                errors++;
                $display("FAIL drop_in_reset[%0d]: got vld=%b data=%h expected 0/0", i, vld_wf, data_wf);
            end
        end
        reset = 1'b0;
        clear_inputs();
        for (int i = 0; i < LAT + 1; i++) begin
            tick();
            checks++;
            if (vld_wf !== 4'b0000 || data_wf !== 64'h0) begin
                errors++;
                $display("FAIL drop_after_reset[%0d]: got vld=%b data=%h expected 0/0", i, vld_wf, data_wf);
            end
        end
        set_read(3, 10'h020);
        tick();
        clear_inputs();
        for (int i = 1; i < LAT; i++) tick();
        checks++;
        if (vld_wf !== 4'b1000) begin
            errors++;
            $display("FAIL drop_read_valid: got %b expected 1000", vld_wf);
        end
        checks++;
        if (data_wf[63:48] !== 16'hAAAA || data_rf[63:48] !== 16'hAAAA) begin
            errors++;
            $display("FAIL drop_kept_word: got wf=%h rf=%h expected aaaa", data_wf[63:48], data_rf[63:48]);
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_write_read();
        test_masked_write();
        test_collision();
        test_back_to_back();
        test_reset_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
